// File: rtl/seq_alu.sv
// seq_alu: valid/ready multi-cycle ALU with signed/unsigned compare, overflow and iterative MULTU/DIVU.
// Build option SEQ_ALU_MULDIV_EN enables the MULTU/DIVU datapath; without it those opcodes are illegal.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [15:0]      imm,
    input  logic             alu_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             overflow_q;
    logic             dbz_q;

    logic             accept;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_hi_d;
    logic             ovf_d;
    logic             dbz_d;
    logic             start_calc;

    assign b_op      = alu_src ? {{(WIDTH-16){imm[15]}}, imm} : b;
    assign sum       = a + b_op;
    assign diff      = a - b_op;
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

    // Single-cycle results, plus the decision whether the accepted op needs the iterative unit.
    always_comb begin
        res_d      = '0;
        res_hi_d   = '0;
        ovf_d      = 1'b0;
        dbz_d      = 1'b0;
        start_calc = 1'b0;
        case (op)
            OP_AND:  res_d = a & b_op;
            OP_OR:   res_d = a | b_op;
            OP_NOR:  res_d = ~(a | b_op);
            OP_ADD: begin
                res_d = sum;
                ovf_d = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff;
                ovf_d = (a[WIDTH-1] != b_op[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b_op))};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a < b_op)};
`ifdef SEQ_ALU_MULDIV_EN
            OP_MULTU: start_calc = 1'b1;
            OP_DIVU: begin
                if (b_op == '0) begin
                    res_d    = '1;
                    res_hi_d = a;
                    dbz_d    = 1'b1;
                end else begin
                    start_calc = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] opnd_b_q;
    logic             is_div_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] step_hi;

    // One iteration: shift-add multiply on {hi,lo}, or restoring divide with hi = remainder, lo = quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_b_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_b_q};
        step_lo   = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        step_hi   = mul_sum[WIDTH:1];
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            count_q     <= '0;
            acc_lo_q    <= '0;
            acc_hi_q    <= '0;
            opnd_b_q    <= '0;
            is_div_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                CALC: begin
`ifdef SEQ_ALU_MULDIV_EN
                    acc_lo_q <= step_lo;
                    acc_hi_q <= step_hi;
                    count_q  <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q     <= DONE;
                        result_q    <= step_lo;
                        result_hi_q <= step_hi;
                        zero_q      <= (step_lo == '0);
                        overflow_q  <= 1'b0;
                        dbz_q       <= 1'b0;
                    end
`else
                    state_q <= IDLE;
`endif
                end
                default: begin
                    // Accepting in DONE retires the previous result on the same edge.
                    if (accept) begin
                        if (start_calc) begin
`ifdef SEQ_ALU_MULDIV_EN
                            state_q  <= CALC;
                            count_q  <= CW'(WIDTH);
                            acc_lo_q <= a;
                            acc_hi_q <= '0;
                            opnd_b_q <= b_op;
                            is_div_q <= (op == OP_DIVU);
`endif
                        end else begin
                            state_q     <= DONE;
                            result_q    <= res_d;
                            result_hi_q <= res_hi_d;
                            zero_q      <= (res_d == '0);
                            overflow_q  <= ovf_d;
                            dbz_q       <= dbz_d;
                        end
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
